// File: rtl/out_arbiter_if.sv
// Output arbiter: shared flow codes and the request/grant bundle.
// Flow codes: HEAD=00, DATA=01, TAIL=10, EMPT=11.
package out_arbiter_pkg;
  localparam int FLOW_W = 2;
  localparam logic [FLOW_W-1:0] FLOW_HEAD = 2'b00;
  localparam logic [FLOW_W-1:0] FLOW_DATA = 2'b01;
  localparam logic [FLOW_W-1:0] FLOW_TAIL = 2'b10;
  localparam logic [FLOW_W-1:0] FLOW_EMPT = 2'b11;
endpackage

interface out_arbiter_if;
  import out_arbiter_pkg::*;
  // reqN bit j: input N wants output j
  logic [3:0]        req0, req1, req2, req3;
  // flow code of the flit currently presented at each input
  logic [FLOW_W-1:0] flow0, flow1, flow2, flow3;
  // gntN bit i: input i owns output N
  logic [3:0]        gnt0, gnt1, gnt2, gnt3;
  logic [3:0]        busy;
  logic [3:0]        tmo;

  modport master (
    output req0, req1, req2, req3, flow0, flow1, flow2, flow3,
    input  gnt0, gnt1, gnt2, gnt3, busy, tmo
  );
  modport slave (
    input  req0, req1, req2, req3, flow0, flow1, flow2, flow3,
    output gnt0, gnt1, gnt2, gnt3, busy, tmo
  );
endinterface

// File: rtl/out_arbiter.sv
// 4x4 output arbiter: one round-robin lock FSM per output, a shared
// per-input block bit that stops a just-served input from re-winning
// until it drops its request.

// Single output: IDLE/LOCK FSM with round-robin pointer and lock timer.
module out_arbiter_port import out_arbiter_pkg::*; #(
  parameter int TMO = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             elig,
  input  logic [3:0][FLOW_W-1:0] flow,
  output logic [3:0]             gnt,
  output logic                   busy,
  output logic                   tmo,
  output logic [3:0]             rel_oh
);
  typedef enum logic {IDLE, LOCK} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] own, own_nxt;
  logic [1:0] sel;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] gnt_nxt;
  logic       tmo_nxt, any, is_tail, is_to, rel;

  // First eligible input scanning from ptr upward (mod 4); reverse loop so
  // the smallest offset is the last (winning) assignment.
  always_comb begin
    sel = ptr;
    any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr + 2'(k)]) begin
        sel = ptr + 2'(k);
        any = 1'b1;
      end
    end
  end

  assign is_tail = (flow[own] == FLOW_TAIL);
  // TMO of zero leaves the lock open until TAIL or reset
  assign is_to   = (TMO != 0) && (cnt == 8'(TMO - 1));

  // Next state: grant from IDLE, release from LOCK on TAIL or timeout
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    own_nxt   = own;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    tmo_nxt   = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_nxt = LOCK;
          own_nxt   = sel;
          gnt_nxt   = 4'b0001 << sel;
          cnt_nxt   = '0;
        end
      end
      LOCK: begin
        if (is_tail || is_to) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = own + 2'd1;
          // TAIL coinciding with the timeout is an ordinary release
          tmo_nxt   = !is_tail;
          rel       = 1'b1;
        end else if (TMO != 0) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any grant at once without a tmo pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      own   <= own_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      tmo   <= tmo_nxt;
    end
  end

  assign busy   = (state == LOCK);
  assign rel_oh = rel ? (4'b0001 << own) : 4'b0000;
endmodule

// Top: per-output FSMs plus the shared input block bits.
module out_arbiter import out_arbiter_pkg::*; #(
  parameter int TMO = 255
) (
  input logic       clk,
  input logic       rst,
  out_arbiter_if.slave io
);
  logic [3:0][3:0]        req;     // [input][output]
  logic [3:0][3:0]        elig;    // [output][input]
  logic [3:0][3:0]        gnt;     // [output][input]
  logic [3:0][3:0]        rel_oh;  // [output][input]
  logic [3:0][FLOW_W-1:0] flow;
  logic [3:0]             blk, blk_set, busy, tmo;

  assign req  = {io.req3, io.req2, io.req1, io.req0};
  assign flow = {io.flow3, io.flow2, io.flow1, io.flow0};

  // Transpose requests per output, masking blocked inputs; gather releases
  always_comb begin
    elig    = '0;
    blk_set = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) elig[j][i] = req[i][j] & ~blk[i];
      blk_set = blk_set | rel_oh[j];
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_port
    out_arbiter_port #(.TMO(TMO)) u_port (
      .clk    (clk),
      .rst    (rst),
      .elig   (elig[j]),
      .flow   (flow),
      .gnt    (gnt[j]),
      .busy   (busy[j]),
      .tmo    (tmo[j]),
      .rel_oh (rel_oh[j])
    );
  end

  // Block a released input until it shows an all-zero request; a release
  // in the same cycle as the zero request keeps it blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (blk_set[i])        blk[i] <= 1'b1;
        else if (req[i] == '0) blk[i] <= 1'b0;
      end
    end
  end

  assign io.gnt0 = gnt[0];
  assign io.gnt1 = gnt[1];
  assign io.gnt2 = gnt[2];
  assign io.gnt3 = gnt[3];
  assign io.busy = busy;
  assign io.tmo  = tmo;
endmodule
